// File: rtl/alu_seq_exec.sv
// Sequential ALU: add/sub/logic in one cycle, shifts and rotates one bit per cycle.
// Valid/ready on both sides; results are held until the consumer takes them.
module alu_seq_exec #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_wr_en,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never drops and payload never changes until that transfer occurs.

    localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3;
    localparam logic [3:0] OP_CMP = 4'd4, OP_AND = 4'd5, OP_ORR = 4'd6, OP_XOR = 4'd7;
    localparam logic [3:0] OP_LSL = 4'd8, OP_LSR = 4'd9, OP_ASR = 4'd10, OP_ROL = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12, OP_ROLC = 4'd13, OP_RORC = 4'd14;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

    state_t state, state_nxt;
    logic   accept, is_shift, go_shift;
    logic [WIDTH-1:0] amt;
    logic [CNT_W-1:0] eff, cnt;
    logic [3:0]       op_q;

    logic [WIDTH-1:0] bb, s_res;
    logic [WIDTH:0]   sum;
    logic             cin, s_c, s_v, s_wr;
    logic [3:0]       s_flags;
    logic [WIDTH-1:0] st_r;
    logic             st_c;

    assign accept   = in_valid & in_ready;
    assign is_shift = (in_op >= OP_LSL) && (in_op <= OP_RORC);
    assign eff      = amt[CNT_W-1:0];
    assign go_shift = is_shift && (eff != '0);

    // Linear shifts saturate at WIDTH; rotates wrap modulo WIDTH.
    always_comb begin
        amt = '0;
        if (in_op == OP_LSL || in_op == OP_LSR || in_op == OP_ASR)
            amt = (in_b >= W_VAL) ? W_VAL : in_b;
        else
            amt = in_b % W_VAL;
    end

    always_comb begin
        bb    = (in_op == OP_SUB || in_op == OP_SBC || in_op == OP_CMP) ? ~in_b : in_b;
        cin   = 1'b0;
        if (in_op == OP_ADC || in_op == OP_SBC) cin = in_flags[0];
        if (in_op == OP_SUB || in_op == OP_CMP) cin = 1'b1;
        sum   = {1'b0, in_a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        s_res = in_a;
        s_c   = in_flags[0];
        s_v   = in_flags[2];
        s_wr  = 1'b1;
        case (in_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                s_res = sum[WIDTH-1:0];
                s_c   = sum[WIDTH];
                s_v   = (in_a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
                s_wr  = (in_op != OP_CMP);
            end
            OP_AND: s_res = in_a & in_b;
            OP_ORR: s_res = in_a | in_b;
            OP_XOR: s_res = in_a ^ in_b;
            4'd15:  s_wr  = 1'b0;
            default: ;
        endcase
        s_flags = {s_res[WIDTH-1], s_v, (s_res == '0), s_c};
        if (in_op == 4'd15) s_flags = in_flags;
    end

    // One shift step on the working value held in out_result, carry in out_flags[0].
    always_comb begin
        st_r = out_result;
        st_c = out_flags[0];
        case (op_q)
            OP_LSL:  begin st_r = {out_result[WIDTH-2:0], 1'b0};           st_c = out_result[WIDTH-1]; end
            OP_LSR:  begin st_r = {1'b0, out_result[WIDTH-1:1]};           st_c = out_result[0]; end
            OP_ASR:  begin st_r = {out_result[WIDTH-1], out_result[WIDTH-1:1]}; st_c = out_result[0]; end
            OP_ROL:  begin st_r = {out_result[WIDTH-2:0], out_result[WIDTH-1]}; st_c = out_result[WIDTH-1]; end
            OP_ROR:  begin st_r = {out_result[0], out_result[WIDTH-1:1]};  st_c = out_result[0]; end
            OP_ROLC: begin st_r = {out_result[WIDTH-2:0], out_flags[0]};   st_c = out_result[WIDTH-1]; end
            OP_RORC: begin st_r = {out_flags[0], out_result[WIDTH-1:1]};   st_c = out_result[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = go_shift ? S_SHIFT : S_DONE;
            S_SHIFT: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE: begin
                if (accept)         state_nxt = go_shift ? S_SHIFT : S_DONE;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
        out_valid = (state == S_DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_flags  <= '0;
            out_wr_en  <= 1'b0;
            cnt        <= '0;
            op_q       <= '0;
        end else if (accept) begin
            op_q <= in_op;
            if (go_shift) begin
                out_result <= in_a;
                out_flags  <= {1'b0, in_flags[2], 1'b0, in_flags[0]};
                out_wr_en  <= 1'b1;
                cnt        <= eff;
            end else begin
                out_result <= s_res;
                out_flags  <= s_flags;
                out_wr_en  <= s_wr;
            end
        end else if (state == S_SHIFT) begin
            out_result <= st_r;
            out_flags  <= {st_r[WIDTH-1], out_flags[2], (st_r == '0), st_c};
            cnt        <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed table, corner sequences, random vs model.
module tb_alu_seq_exec;

    logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_wr_en;
    logic [3:0] in_op, in_flags, out_flags;
    logic [7:0] in_a, in_b, out_result;
    logic [1:0] dbg_state;

    int tests  = 0;
    int failed = 0;
    logic [7:0] exp_q[$];

    alu_seq_exec #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_wr_en(out_wr_en), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
        logic [7:0] res;
        logic [3:0] fl;
        logic       wr;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-value arithmetic on ints, straight from the op definitions.
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f, output logic [7:0] r, output logic [3:0] fl,
                         output logic wr, output int lat);
        int ai, bi, ci, sa, sb, t, d, c, v, n, x, y;
        ai = a; bi = b; ci = f[0]; sa = $signed(a); sb = $signed(b);
        c = ci; v = f[2]; r = a; wr = 1'b1; lat = 1; n = 0; t = 0; d = 0;
        case (op)
            4'd0, 4'd1: begin
                t = ai + bi + ((op == 4'd1) ? ci : 0);
                d = sa + sb + ((op == 4'd1) ? ci : 0);
                r = t[7:0]; c = (t > 255) ? 1 : 0; v = (d < -128 || d > 127) ? 1 : 0;
            end
            4'd2, 4'd4: begin
                t = ai - bi; d = sa - sb;
                r = t[7:0]; c = (ai >= bi) ? 1 : 0; v = (d < -128 || d > 127) ? 1 : 0;
                wr = (op != 4'd4);
            end
            4'd3: begin
                t = ai - bi - (1 - ci); d = sa - sb - (1 - ci);
                r = t[7:0]; c = (t >= 0) ? 1 : 0; v = (d < -128 || d > 127) ? 1 : 0;
            end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8, 4'd9, 4'd10: begin
                n = (bi > 8) ? 8 : bi;
                if (n > 0) begin
                    if (op == 4'd8)      begin t = ai << n; r = t[7:0]; c = t[8]; end
                    else if (op == 4'd9) begin t = ai >> n; r = t[7:0]; c = (ai >> (n - 1)) & 1; end
                    else                 begin t = sa >>> n; r = t[7:0]; c = (sa >>> (n - 1)) & 1; end
                end
            end
            4'd11, 4'd12, 4'd13, 4'd14: begin
                n = bi % 8;
                if (n > 0) begin
                    if (op == 4'd11)      begin t = ((ai << n) | (ai >> (8 - n))) & 255; r = t[7:0]; c = t & 1; end
                    else if (op == 4'd12) begin t = ((ai >> n) | (ai << (8 - n))) & 255; r = t[7:0]; c = (t >> 7) & 1; end
                    else begin
                        x = (ci << 8) | ai;
                        if (op == 4'd13) y = ((x << n) | (x >> (9 - n))) & 511;
                        else             y = ((x >> n) | (x << (9 - n))) & 511;
                        r = y[7:0]; c = y >> 8;
                    end
                end
            end
            default: wr = 1'b0;
        endcase
        fl = {r[7], v[0], (r == 8'h00), c[0]};
        if (op == 4'd15) fl = f;
        if (op >= 4'd8 && op <= 4'd14 && n > 0) lat = n + 1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, output logic [7:0] r, output logic [3:0] fl,
                        output logic wr, output int lat);
        int guard;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_flags = f; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            tests++; failed++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 4'($urandom); in_a = 8'($urandom); in_b = 8'($urandom); in_flags = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = out_result; fl = out_flags; wr = out_wr_en;
    endtask

    task automatic run_vec(input string name, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] f, input logic [7:0] er,
                           input logic [3:0] ef, input logic ew, input int el);
        logic [7:0] r;
        logic [3:0] fl;
        logic       wr;
        int         lat;
        send(op, a, b, f, r, fl, wr, lat);
        check({name, "_result"}, 32'(r), 32'(er));
        check({name, "_flags"}, 32'(fl), 32'(ef));
        check({name, "_wr_en"}, 32'(wr), 32'(ew));
        check({name, "_latency"}, 32'(lat), 32'(el));
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mr;
        logic [3:0] mf, op, f;
        logic [7:0] a, b;
        logic       mw;
        int         ml;

        tbl[0]  = '{4'd0,  8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0011, 1'b1, 1};
        tbl[1]  = '{4'd2,  8'h80, 8'h01, 4'b0000, 8'h7F, 4'b0101, 1'b1, 1};
        tbl[2]  = '{4'd4,  8'h05, 8'h05, 4'b0000, 8'h00, 4'b0011, 1'b0, 1};
        tbl[3]  = '{4'd8,  8'h81, 8'h03, 4'b0000, 8'h08, 4'b0000, 1'b1, 4};
        tbl[4]  = '{4'd10, 8'h80, 8'd20, 4'b0000, 8'hFF, 4'b1001, 1'b1, 9};
        tbl[5]  = '{4'd14, 8'h01, 8'h01, 4'b0000, 8'h00, 4'b0011, 1'b1, 2};
        tbl[6]  = '{4'd11, 8'h3C, 8'h08, 4'b0101, 8'h3C, 4'b0101, 1'b1, 1};
        tbl[7]  = '{4'd15, 8'hAA, 8'h12, 4'b1010, 8'hAA, 4'b1010, 1'b0, 1};
        tbl[8]  = '{4'd1,  8'h7F, 8'h00, 4'b0001, 8'h80, 4'b1100, 1'b1, 1};
        tbl[9]  = '{4'd5,  8'hF0, 8'h0F, 4'b0110, 8'h00, 4'b0110, 1'b1, 1};
        tbl[10] = '{4'd3,  8'h00, 8'h00, 4'b0000, 8'hFF, 4'b1000, 1'b1, 1};
        tbl[11] = '{4'd12, 8'h01, 8'h01, 4'b0000, 8'h80, 4'b1001, 1'b1, 2};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_flags = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(out_result), 32'd0);
        check("reset_flags", 32'(out_flags), 32'd0);
        check("reset_wr_en", 32'(out_wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].f,
                    tbl[i].res, tbl[i].fl, tbl[i].wr, tbl[i].lat);

        // Back-to-back adds: one result per cycle with no bubble.
        drain();
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            model(4'd0, a, b, 4'b0000, mr, mf, mw, ml);
            exp_q.push_back(mr);
            @(negedge clk);
            in_op = 4'd0; in_a = a; in_b = b; in_flags = 4'b0000; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("b2b%0d_result", i), 32'(out_result), 32'(exp_q.pop_front()));
            check($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        drain();
        check("b2b_idle_after", 32'(out_valid), 32'd0);

        // Consumer stall: outputs held, no new accept.
        @(negedge clk);
        in_op = 4'd7; in_a = 8'h5A; in_b = 8'hFF; in_flags = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_result", i), 32'(out_result), 32'hA5);
            check($sformatf("stall%0d_flags", i), 32'(out_flags), 32'b1000);
            check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        drain();
        check("stall_release_idle", 32'(out_valid), 32'd0);

        // Reset during the second step of an lsr.
        @(negedge clk);
        in_op = 4'd9; in_a = 8'hF0; in_b = 8'd5; in_flags = 4'b0000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_result", 32'(out_result), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst_add", 4'd0, 8'h12, 8'h34, 4'b0000, 8'h46, 4'b0000, 1'b1, 1);
        drain();
        check("post_rst_idle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            f  = 4'($urandom);
            model(op, a, b, f, mr, mf, mw, ml);
            run_vec($sformatf("rnd%0d_op%0d", i, op), op, a, b, f, mr, mf, mw, ml);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
